// File: rtl/matriz_pkg.sv
// matriz_pkg: shared matrix defaults, column active-level encoding and row-word type
package matriz_pkg;
  localparam int N_LIN_PAD = 7;
  localparam int N_COL_PAD = 5;
  typedef enum logic {COL_BAIXO = 1'b0, COL_ALTO = 1'b1} col_ativo_e;
  typedef logic [N_LIN_PAD-1:0] linha_t;
  function automatic int col_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matriz_leds_varredura_if.sv
// matriz_leds_varredura_if: back-buffer write bus from game logic to the scan driver
import matriz_pkg::*;
interface matriz_leds_varredura_if #(
  parameter int N_LIN = N_LIN_PAD,
  parameter int N_COL = N_COL_PAD
);
  logic wr_en;
  logic [col_w(N_COL)-1:0] wr_col;
  logic [N_LIN-1:0] wr_data;
  logic [N_LIN-1:0] wr_blink;
  modport master (output wr_en, wr_col, wr_data, wr_blink);
  modport slave (input wr_en, wr_col, wr_data, wr_blink);
endinterface

// File: rtl/gerador_tick.sv
// gerador_tick: prescaler counting 0..PRESC-1 while enabled, tick on the last count
module gerador_tick #(
  parameter int PRESC = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(PRESC);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(PRESC - 1);
  always_ff @(posedge clock)
    cnt <= (reset || !enable || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/matriz_leds_varredura.sv
// matriz_leds_varredura: double-buffered N_LIN x N_COL LED matrix column scanner
// Optional blink plane enabled by defining MATRIZ_BLINK_EN.
import matriz_pkg::*;
module matriz_leds_varredura #(
  parameter int   N_LIN     = N_LIN_PAD,
  parameter int   N_COL     = N_COL_PAD,
  parameter int   PRESC     = 65536,
  parameter logic COL_ATIVO = COL_BAIXO,
  parameter int   BLINK_FR  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  matriz_leds_varredura_if.slave   wr,
  output logic [N_LIN-1:0]         linhas,
  output logic [N_COL-1:0]         colunas,
  output logic                     frame_start
);
  localparam int CW = col_w(N_COL);
  logic [N_LIN-1:0] back [N_COL];
  logic [N_LIN-1:0] front [N_COL];
  logic [N_LIN-1:0] back_nxt [N_COL];
  logic [CW-1:0] col_idx, col_nxt;
  logic [N_COL-1:0] col_sel;
  logic [N_LIN-1:0] lin_nxt, lin_out;
  logic scan, tick, wrap;
  gerador_tick #(.PRESC(PRESC)) u_tick (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );
  // scan=0 means nothing driven yet, so the first tick lands on column 0 and commits
  always_comb begin
    for (int i = 0; i < N_COL; i++)
      back_nxt[i] = (wr.wr_en && wr.wr_col == CW'(i)) ? wr.wr_data : back[i];
    col_nxt = (!scan || col_idx == CW'(N_COL - 1)) ? '0 : col_idx + 1'b1;
    wrap = col_nxt == '0;
    for (int j = 0; j < N_COL; j++)
      col_sel[j] = (col_nxt == CW'(j)) ? COL_ATIVO : ~COL_ATIVO;
    lin_nxt = wrap ? back_nxt[0] : front[col_nxt];
  end
`ifdef MATRIZ_BLINK_EN
  localparam int FW = $clog2(BLINK_FR + 1);
  logic [N_LIN-1:0] back_blk [N_COL];
  logic [N_LIN-1:0] front_blk [N_COL];
  logic [N_LIN-1:0] blk_nxt [N_COL];
  logic [N_LIN-1:0] mask;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic phase, phase_nxt, ph;
  // fcnt counts frames shown in the current phase; the frame that reaches BLINK_FR+1 flips it
  always_comb begin
    for (int i = 0; i < N_COL; i++)
      blk_nxt[i] = (wr.wr_en && wr.wr_col == CW'(i)) ? wr.wr_blink : back_blk[i];
    phase_nxt = (fcnt == FW'(BLINK_FR)) ? ~phase : phase;
    fcnt_nxt = (fcnt == FW'(BLINK_FR)) ? FW'(1) : fcnt + 1'b1;
    mask = wrap ? blk_nxt[0] : front_blk[col_nxt];
    ph = wrap ? phase_nxt : phase;
    lin_out = ph ? (lin_nxt & ~mask) : lin_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_COL; i++) begin
        back_blk[i] <= '0;
        front_blk[i] <= '0;
      end
      phase <= 1'b0;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < N_COL; i++)
        back_blk[i] <= blk_nxt[i];
      if (!enable) begin
        for (int i = 0; i < N_COL; i++)
          front_blk[i] <= blk_nxt[i];
        phase <= 1'b0;
        fcnt <= '0;
      end else if (tick && wrap) begin
        for (int i = 0; i < N_COL; i++)
          front_blk[i] <= blk_nxt[i];
        phase <= phase_nxt;
        fcnt <= fcnt_nxt;
      end
    end
  end
`else
  logic unused_blk;
  assign unused_blk = ^{wr.wr_blink, 1'(BLINK_FR)};
  assign lin_out = lin_nxt;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_COL; i++) begin
        back[i] <= '0;
        front[i] <= '0;
      end
      col_idx <= '0;
      scan <= 1'b0;
      linhas <= '0;
      colunas <= {N_COL{~COL_ATIVO}};
      frame_start <= 1'b0;
    end else begin
      for (int i = 0; i < N_COL; i++)
        back[i] <= back_nxt[i];
      frame_start <= tick && wrap;
      if (!enable) begin
        for (int i = 0; i < N_COL; i++)
          front[i] <= back_nxt[i];
        col_idx <= '0;
        scan <= 1'b0;
        linhas <= '0;
        colunas <= {N_COL{~COL_ATIVO}};
      end else if (tick) begin
        if (wrap)
          for (int i = 0; i < N_COL; i++)
            front[i] <= back_nxt[i];
        col_idx <= col_nxt;
        scan <= 1'b1;
        linhas <= lin_out;
        colunas <= col_sel;
      end
    end
  end
endmodule

// File: tb/tb_matriz_leds_varredura.sv
// tb_matriz_leds_varredura: directed checks of the scan driver (PRESC=4, 7x5, BLINK_FR=2)
module tb_matriz_leds_varredura;
  logic clk = 1'b0;
  logic reset, enable, frame_start;
  logic [6:0] linhas;
  logic [4:0] colunas;
  int n_cmp = 0;
  int n_err = 0;
  matriz_leds_varredura_if #(.N_LIN(7), .N_COL(5)) wr_if ();
  matriz_leds_varredura #(
    .N_LIN(7), .N_COL(5), .PRESC(4), .COL_ATIVO(1'b0), .BLINK_FR(2)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .wr         (wr_if.slave),
    .linhas     (linhas),
    .colunas    (colunas),
    .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic blank(input string tag);
    step();
    chk({tag, "_lin"}, linhas, 7'h00);
    chk({tag, "_col"}, colunas, 5'h1F);
    chk({tag, "_fs"}, frame_start, 1'b0);
  endtask
  // one full 20-cycle frame; optional write driven after cycle wr_at, sampled on the next edge
  task automatic frame(input logic [4:0][6:0] exp, input int wr_at, input logic [2:0] col,
                       input logic [6:0] dat, input logic [6:0] blk);
    logic [4:0] ecol;
    for (int i = 0; i < 20; i++) begin
      step();
      ecol = ~(5'd1 << (i / 4));
      chk("colunas", colunas, ecol);
      chk("linhas", linhas, exp[i/4]);
      chk("frame_start", frame_start, (i == 0) ? 1'b1 : 1'b0);
      wr_if.wr_en = (i == wr_at);
      wr_if.wr_col = col;
      wr_if.wr_data = dat;
      wr_if.wr_blink = blk;
    end
  endtask
  initial begin
    logic [4:0][6:0] e0, e1, e2;
    logic [6:0] c1 [5];
`ifdef MATRIZ_BLINK_EN
    c1 = '{7'h03, 7'h02, 7'h02, 7'h03, 7'h03};
`else
    c1 = '{7'h03, 7'h03, 7'h03, 7'h03, 7'h03};
`endif
    e0 = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
    e1 = {7'h10, 7'h7F, 7'h04, 7'h02, 7'h01};
    e2 = {7'h10, 7'h7F, 7'h55, 7'h02, 7'h01};
    reset = 1'b1;
    enable = 1'b0;
    wr_if.wr_en = 1'b0;
    wr_if.wr_col = '0;
    wr_if.wr_data = '0;
    wr_if.wr_blink = '0;
    for (int i = 0; i < 3; i++) blank("rst");
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr_if.wr_en = 1'b1;
      wr_if.wr_col = 3'(k);
      wr_if.wr_data = 7'(1 << k);
      blank("wr_dis");
    end
    wr_if.wr_en = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) blank("pre");
    frame(e0, -1, 3'd0, 7'h00, 7'h00);
    frame(e0, -1, 3'd0, 7'h00, 7'h00);
    frame(e0, 2, 3'd3, 7'h7F, 7'h00);
    frame(e1, 19, 3'd2, 7'h55, 7'h00);
    frame(e2, 3, 3'd5, 7'h7F, 7'h00);
    frame(e2, -1, 3'd0, 7'h00, 7'h00);
    for (int i = 0; i < 6; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) blank("dis");
    enable = 1'b1;
    for (int i = 0; i < 3; i++) blank("reen");
    frame(e2, 19, 3'd1, 7'h03, 7'h01);
    for (int r = 0; r < 5; r++)
      frame({7'h10, 7'h7F, 7'h55, c1[r], 7'h01}, -1, 3'd0, 7'h00, 7'h00);
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    wr_if.wr_en = 1'b1;
    wr_if.wr_col = 3'd0;
    wr_if.wr_data = 7'h7F;
    wr_if.wr_blink = 7'h7F;
    blank("rst_mid");
    reset = 1'b0;
    wr_if.wr_en = 1'b0;
    for (int i = 0; i < 3; i++) blank("post_rst");
    frame('0, -1, 3'd0, 7'h00, 7'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
